// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the multicycle PC sequencer and the PC source mux.
package pc_seq_pkg;

  // Opcode classes decoded by the sequencer; every other opcode is ordinary.
  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BEQZ = 4'hD;
  localparam logic [3:0] OP_BNEG = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Next-PC select encodings, shared with the PC source mux.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_CONCAT = 2'b01;
  localparam logic [1:0] PCSRC_INC    = 2'b10;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_JUMP,
    S_JREG,
    S_BRANCH,
    S_HALT
  } state_t;

  // State entered after DECODE for a given opcode.
  function automatic state_t resolve_state(input logic [3:0] op);
    case (op)
      OP_JMP:           return S_JUMP;
      OP_JR:            return S_JREG;
      OP_BEQZ, OP_BNEG: return S_BRANCH;
      OP_HALT:          return S_HALT;
      default:          return S_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bundle between the sequencer and the IR / ALU / PC datapath.
interface pc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       Opcode;
  logic             ALUZero;
  logic             ALUNeg;
  logic             Stall;
  logic [1:0]       PCSrc;
  logic             PCWrite;
  logic             IRWrite;
  logic             MemRead;
  logic             Retire;
  logic             Halted;
  logic [CNT_W-1:0] RetireCount;

  // Sequencer side: consumes opcode/flags/stall, drives the PC controls.
  modport master (
    input  Opcode, ALUZero, ALUNeg, Stall,
    output PCSrc, PCWrite, IRWrite, MemRead, Retire, Halted, RetireCount
  );

  // Datapath side: supplies opcode/flags/stall, obeys the PC controls.
  modport slave (
    output Opcode, ALUZero, ALUNeg, Stall,
    input  PCSrc, PCWrite, IRWrite, MemRead, Retire, Halted, RetireCount
  );
endinterface

// File: rtl/pc_sequencer_retire_counter.sv
// Wrapping retired-instruction counter with enable and async active-low clear.
module retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles; all-ones rolls over to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle PC sequencer: FETCH -> DECODE -> resolve, with stall freeze,
// sticky HALT and a retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           CLK,
  input  logic           Reset_n,
  pc_sequencer_if.master bus
);

  state_t state;
  logic   is_bneg;   // branch kind captured in DECODE, so outputs never see Opcode
  logic   frozen;
  logic   taken;

  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       irwrite;
  logic       memread;
  logic       retire;
  logic       halted;

  // A stall freezes everything except a halted sequencer.
  assign frozen = bus.Stall && (state != S_HALT);
  assign taken  = is_bneg ? bus.ALUNeg : bus.ALUZero;

  // Next-state register; the branch kind is latched while leaving DECODE.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_START;
      is_bneg <= 1'b0;
    end else if (!frozen) begin
      unique case (state)
        S_START:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          state   <= resolve_state(bus.Opcode);
          is_bneg <= (bus.Opcode == OP_BNEG);
        end
        S_EXEC, S_JUMP, S_JREG, S_BRANCH: state <= S_FETCH;
        S_HALT:   state <= S_HALT;
      endcase
    end
  end

  // Moore output decode of the state, then the stall gating on top.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pcsrc   = PCSRC_INC;
    pcwrite = 1'b0;
    irwrite = 1'b0;
    memread = 1'b0;
    retire  = 1'b0;
    halted  = 1'b0;
    unique case (state)
      S_START:  ;
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        pcwrite = 1'b1;
      end
      S_DECODE: ;
      S_EXEC:   retire = 1'b1;
      S_JUMP: begin
        pcsrc   = PCSRC_CONCAT;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      S_JREG: begin
        pcsrc   = PCSRC_ALU;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        retire = 1'b1;
        if (taken) begin
          pcsrc   = PCSRC_ALU;
          pcwrite = 1'b1;
        end
      end
      S_HALT:   halted = 1'b1;
    endcase
    // Memory read stays asserted while stalled so the access can complete.
    if (frozen) begin
      pcwrite = 1'b0;
      irwrite = 1'b0;
      retire  = 1'b0;
      pcsrc   = PCSRC_INC;
    end
  end

  assign bus.PCSrc   = pcsrc;
  assign bus.PCWrite = pcwrite;
  assign bus.IRWrite = irwrite;
  assign bus.MemRead = memread;
  assign bus.Retire  = retire;
  assign bus.Halted  = halted;

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk   (CLK),
    .rst_n (Reset_n),
    .en    (retire),
    .count (bus.RetireCount)
  );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multicycle control sequencer that drives the program-counter source select and write enable consumed by the PC source mux and PC register. Each instruction walks Fetch → Decode → a resolve state that chooses ALU result, concatenated jump target, or PC increment as the next PC. The block sits between the instruction register's opcode field / ALU flags and the PC datapath. It also counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of RetireCount.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Opcode  input  4  opcode field of the instruction register, valid from DECODE onward.
- ALUZero  input  1  accumulator == 0 flag.
- ALUNeg  input  1  accumulator sign flag.
- Stall  input  1  memory not ready; freezes the sequencer.
- PCSrc  output  2  next-PC select: 2'b00 ALU result, 2'b01 concatenated target, 2'b10 PC increment.
- PCWrite  output  1  load PC from the selected source.
- IRWrite  output  1  load instruction register.
- MemRead  output  1  instruction memory read strobe.
- Retire  output  1  one-cycle pulse in the final cycle of each completed instruction.
- Halted  output  1  sequencer stopped on HALT.
- RetireCount  output  CNT_W  retired-instruction count.

## Operation
- Opcode classes: 4'hB JR (target = ALU result), 4'hC JMP (concatenated target), 4'hD BEQZ, 4'hE BNEG, 4'hF HALT, all others ORD.
- States: START, FETCH, DECODE, EXEC, JUMP, JREG, BRANCH, HALT.
- START: all enables 0 → FETCH.
- FETCH: MemRead=1, IRWrite=1, PCWrite=1, PCSrc=10 → DECODE.
- DECODE: no enables. ORD→EXEC, JMP→JUMP, JR→JREG, BEQZ/BNEG→BRANCH, HALT→HALT. During DECODE the ALU forms the branch target.
- EXEC: Retire=1 → FETCH.
- JUMP: PCSrc=01, PCWrite=1, Retire=1 → FETCH.
- JREG: PCSrc=00, PCWrite=1, Retire=1 → FETCH.
- BRANCH: taken when (BEQZ & ALUZero) or (BNEG & ALUNeg).
  - Taken: PCSrc=00, PCWrite=1.
  - Not taken: PCWrite=0, PCSrc=10.
  - Either way: Retire=1 → FETCH.
- HALT: Halted=1, all enables 0. Sticky until reset; not counted as retired.
- PCSrc is 2'b10 in every state or cycle where PCWrite=0.
- Stall=1 in any state except HALT:
  - State held.
  - PCWrite, IRWrite and Retire forced to 0; MemRead keeps its state value.
  - Counter held.
- RetireCount increments by 1 on each Retire cycle and wraps modulo 2^CNT_W (all-ones → 0), no saturation.

## Timing
- Reset (asynchronous, any state):
  - State = START.
  - PCSrc=10; PCWrite, IRWrite, MemRead, Retire, Halted all 0.
  - RetireCount=0.
- Outputs are Moore decodes of the registered state, gated by Stall. No output depends combinationally on Opcode; BRANCH outputs depend combinationally on ALUZero/ALUNeg.
- Without stalls, every non-HALT instruction takes 3 cycles (FETCH, DECODE, resolve). The first FETCH follows 1 cycle of START after reset release.
- RetireCount shows the new value the cycle after Retire.
- Reset asserted mid-instruction discards the instruction: no Retire, no PCWrite after assertion.
- Stall is sampled every cycle; each stalled cycle adds exactly one cycle of latency.

## Structure
- Shared package pc_seq_pkg:
  - opcode constants OP_JR, OP_JMP, OP_BEQZ, OP_BNEG, OP_HALT;
  - PCSrc encodings PCSRC_ALU=2'b00, PCSRC_CONCAT=2'b01, PCSRC_INC=2'b10 (shared with the PC mux);
  - state encoding.
- One sub-module, retire_counter: CNT_W-bit wrapping counter with enable and async active-low clear.
- Remaining logic is a single next-state block plus an output-decode block.

## Test plan
- Reset release, Opcode=4'h1 → START, then FETCH (PCWrite=1, PCSrc=10, IRWrite=1), DECODE, EXEC (Retire=1). RetireCount=1 four cycles after release.
- Opcode=4'hC → JUMP cycle has PCSrc=01, PCWrite=1. Opcode=4'hB → JREG cycle has PCSrc=00, PCWrite=1.
- BEQZ (Opcode=4'hD):
  - ALUZero=1 → BRANCH PCSrc=00, PCWrite=1.
  - ALUZero=0 → PCWrite=0, PCSrc=10, Retire=1 in both cases.
  - BNEG (Opcode=4'hE) checked the same way with ALUNeg.
- Stall=1 for 3 cycles during FETCH → state held, PCWrite/IRWrite=0, MemRead=1. The instruction completes 3 cycles late and RetireCount advances by exactly 1.
- Opcode=4'hF → HALT: Halted=1, no enables for 20 cycles, RetireCount unchanged. Reset_n pulse → START, Halted=0.
- Preload RetireCount to 16'hFFFF via 65535 ORD instructions (or force), retire one more → 16'h0000. Reset_n asserted during DECODE → no Retire, RetireCount=0.
